// File: rtl/fft_result_reader_pkg.sv
// Shared FFT drain-side types: reader FSM states, exponent width and the
// read-credit helper used by the result reader.
package fft_result_reader_pkg;

    localparam int BFP_EXP_W = 8;

    typedef enum logic [2:0] {
        RD_IDLE     = 3'd0,
        RD_DRAIN    = 3'd1,
        RD_FLUSH    = 3'd2,
        RD_FIN      = 3'd3,
        RD_WAIT_CLR = 3'd4
    } rd_state_t;

    // True when a new read fits: buffered + in-flight - leaving this cycle < 2.
    function automatic logic credit_ok(input logic [1:0] count,
                                       input logic       inflight,
                                       input logic       pop);
        return ({1'b0, count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
    endfunction

endpackage

// File: rtl/fft_rd_fifo2.sv
// Two-entry FIFO holding tagged FFT bins between the DMA read port and the
// output stream. Simultaneous push and pop on a full FIFO is allowed.
module fft_rd_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] mem_r [2];
    logic         wr_ptr_r;
    logic         rd_ptr_r;
    logic [1:0]   count_r;

    // Storage, pointers and occupancy; storage is cleared so an empty head reads 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_r[0] <= '0;
            mem_r[1] <= '0;
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/fft_result_reader.sv
// Drains FFT bins 0..OUT_BINS-1 over the core's DMA read bus into a
// valid/ready stream, then pulses fin to hand the core back to input streaming.
module fft_result_reader
    import fft_result_reader_pkg::*;
#(
    parameter int FFT_LENGTH = 1024,
    parameter int FFT_DW     = 16,
    parameter int OUT_BINS   = FFT_LENGTH / 2,
    parameter int FFT_N      = $clog2(FFT_LENGTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        done,
    input  logic signed [BFP_EXP_W-1:0] bfpexp,
    output logic                        fin,
    output logic                        dmaact,
    output logic [FFT_N-1:0]            dmaa,
    input  logic signed [FFT_DW-1:0]    dmadr_real,
    input  logic signed [FFT_DW-1:0]    dmadr_imag,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic signed [FFT_DW-1:0]    m_real,
    output logic signed [FFT_DW-1:0]    m_imag,
    output logic [FFT_N-1:0]            m_index,
    output logic signed [BFP_EXP_W-1:0] m_exp,
    output logic                        m_last,
    output logic                        busy
);

    localparam int FW = 2 * FFT_DW + FFT_N + 1;

    rd_state_t                 state_r;
    rd_state_t                 state_s;
    logic [FFT_N-1:0]          cnt_r;
    logic                      inflight_r;
    logic [FFT_N-1:0]          infl_idx_r;
    logic                      infl_last_r;
    logic signed [BFP_EXP_W-1:0] exp_r;
    logic                      fin_r;
    logic                      busy_r;
    logic                      issue_s;
    logic                      pop_s;
    logic                      last_addr_s;
    logic [1:0]                fifo_count_s;
    logic [FW-1:0]             fifo_head_s;
    logic [FW-1:0]             push_data_s;

    assign m_valid     = (fifo_count_s != 2'd0);
    assign pop_s       = m_valid && m_ready;
    assign last_addr_s = (cnt_r == FFT_N'(OUT_BINS - 1));
    assign push_data_s = {infl_last_r, infl_idx_r, dmadr_imag, dmadr_real};

    // Next-state and read-issue decision; reads only go out while draining.
    always_comb begin
        state_s = state_r;
        issue_s = 1'b0;
        case (state_r)
            RD_IDLE: begin
                if (done) begin
                    state_s = RD_DRAIN;
                end else begin
                    state_s = RD_IDLE;
                end
            end
            RD_DRAIN: begin
                issue_s = credit_ok(fifo_count_s, inflight_r, pop_s);
                if (issue_s && last_addr_s) begin
                    state_s = RD_FLUSH;
                end else begin
                    state_s = RD_DRAIN;
                end
            end
            RD_FLUSH: begin
                if (!inflight_r && (fifo_count_s == 2'd0)) begin
                    state_s = RD_FIN;
                end else begin
                    state_s = RD_FLUSH;
                end
            end
            RD_FIN: begin
                state_s = RD_WAIT_CLR;
            end
            RD_WAIT_CLR: begin
                // Holding here until done drops keeps the same frame from draining twice.
                if (!done) begin
                    state_s = RD_IDLE;
                end else begin
                    state_s = RD_WAIT_CLR;
                end
            end
            default: begin
                state_s = RD_IDLE;
            end
        endcase
    end

    // State, address counter, in-flight read tag, exponent latch and status flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= RD_IDLE;
            cnt_r       <= '0;
            inflight_r  <= 1'b0;
            infl_idx_r  <= '0;
            infl_last_r <= 1'b0;
            exp_r       <= '0;
            fin_r       <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            inflight_r <= issue_s;
            if (issue_s) begin
                infl_idx_r  <= cnt_r;
                infl_last_r <= last_addr_s;
            end
            if ((state_r == RD_IDLE) && done) begin
                cnt_r <= '0;
                exp_r <= bfpexp;
            end else if (issue_s && !last_addr_s) begin
                // The counter parks on the final address so dmaa holds it afterwards.
                cnt_r <= cnt_r + FFT_N'(1);
            end
            fin_r  <= (state_s == RD_FIN);
            busy_r <= (state_s != RD_IDLE);
        end
    end

    fft_rd_fifo2 #(
        .W(FW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (inflight_r),
        .push_data(push_data_s),
        .pop      (pop_s),
        .head     (fifo_head_s),
        .count    (fifo_count_s)
    );

    assign dmaact  = issue_s;
    assign dmaa    = cnt_r;
    assign fin     = fin_r;
    assign busy    = busy_r;
    assign m_exp   = exp_r;
    assign m_real  = fifo_head_s[FFT_DW-1:0];
    assign m_imag  = fifo_head_s[2*FFT_DW-1:FFT_DW];
    assign m_index = fifo_head_s[2*FFT_DW +: FFT_N];
    assign m_last  = fifo_head_s[FW-1];

endmodule

// File: tb/tb_fft_result_reader.sv
// Directed bench for fft_result_reader: scoreboard of expected bins, RAM model
// returning real=address / imag=-address, plus a single-bin instance.
module tb_fft_result_reader;

    localparam int FFT_LENGTH = 16;
    localparam int FFT_DW     = 16;
    localparam int OUT_BINS   = 8;
    localparam int FFT_N      = 4;

    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
        logic [3:0]         idx;
        logic signed [7:0]  ex;
        logic               last;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst, done, fin, dmaact, m_valid, m_ready, m_last, busy;
    logic signed [7:0]        bfpexp, m_exp;
    logic [FFT_N-1:0]         dmaa, m_index;
    logic signed [FFT_DW-1:0] dmadr_real, dmadr_imag, m_real, m_imag;

    logic                     done1, fin1, dmaact1, m_valid1, m_ready1, m_last1, busy1;
    logic signed [7:0]        m_exp1;
    logic [FFT_N-1:0]         dmaa1, m_index1;
    logic signed [FFT_DW-1:0] dmadr_real1, dmadr_imag1, m_real1, m_imag1;

    fft_result_reader #(.FFT_LENGTH(FFT_LENGTH), .FFT_DW(FFT_DW), .OUT_BINS(OUT_BINS)) u_dut (
        .clk(clk), .rst(rst), .done(done), .bfpexp(bfpexp), .fin(fin),
        .dmaact(dmaact), .dmaa(dmaa), .dmadr_real(dmadr_real), .dmadr_imag(dmadr_imag),
        .m_valid(m_valid), .m_ready(m_ready), .m_real(m_real), .m_imag(m_imag),
        .m_index(m_index), .m_exp(m_exp), .m_last(m_last), .busy(busy)
    );

    fft_result_reader #(.FFT_LENGTH(FFT_LENGTH), .FFT_DW(FFT_DW), .OUT_BINS(1)) u_dut1 (
        .clk(clk), .rst(rst), .done(done1), .bfpexp(bfpexp), .fin(fin1),
        .dmaact(dmaact1), .dmaa(dmaa1), .dmadr_real(dmadr_real1), .dmadr_imag(dmadr_imag1),
        .m_valid(m_valid1), .m_ready(m_ready1), .m_real(m_real1), .m_imag(m_imag1),
        .m_index(m_index1), .m_exp(m_exp1), .m_last(m_last1), .busy(busy1)
    );

    // Core RAM models: one-cycle read latency.
    always @(posedge clk) begin
        if (dmaact) begin
            dmadr_real <= $signed({12'd0, dmaa});
            dmadr_imag <= -$signed({12'd0, dmaa});
        end
        if (dmaact1) begin
            dmadr_real1 <= $signed({12'd0, dmaa1});
            dmadr_imag1 <= -$signed({12'd0, dmaa1});
        end
    end

    int    vec_cnt = 0;
    int    err_cnt = 0;
    beat_t sb_q[$];
    beat_t mb;
    int    cyc = 0, last_hs_cyc = -100, fin_cnt = 0;
    int    iss_total = 0, pop_total = 0, iss_all = 0, pop_all = 0, frame_addr = 0;
    logic  stall_prev = 1'b0;
    logic [44:0] held;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic signed [7:0] e);
        beat_t b;
        for (int i = 0; i < OUT_BINS; i++) begin
            b.re   = 16'(i);
            b.im   = -16'(i);
            b.idx  = 4'(i);
            b.ex   = e;
            b.last = (i == OUT_BINS - 1);
            sb_q.push_back(b);
        end
    endtask

    task automatic wait_fin(input int target, input string tag);
        for (int k = 0; k < 400 && fin_cnt < target; k++) tick();
        chk(tag, fin_cnt, target);
        chk({tag, "_drained"}, sb_q.size(), 0);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 50 && busy; k++) tick();
        chk("idle", busy, 1'b0);
    endtask

    // Output monitor: scoreboard, hold-while-stalled, address order, credit, fin spacing.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            iss_total  = 0;
            pop_total  = 0;
            stall_prev = 1'b0;
        end else begin
            if (!busy) frame_addr = 0;
            if (stall_prev) chk("stall_hold", {m_real, m_imag, m_index, m_exp, m_last}, held);
            if (m_valid && m_ready) begin
                pop_total++;
                pop_all++;
                chk("sb_nonempty", sb_q.size() > 0, 1'b1);
                if (sb_q.size() > 0) begin
                    mb = sb_q.pop_front();
                    chk("beat_real", m_real, mb.re);
                    chk("beat_imag", m_imag, mb.im);
                    chk("beat_index", m_index, mb.idx);
                    chk("beat_exp", m_exp, mb.ex);
                    chk("beat_last", m_last, mb.last);
                end
                if (m_last) last_hs_cyc = cyc;
            end
            stall_prev = m_valid && !m_ready;
            held       = {m_real, m_imag, m_index, m_exp, m_last};
            if (dmaact) begin
                chk("dmaa", dmaa, frame_addr);
                frame_addr++;
                iss_total++;
                iss_all++;
                chk("credit", (iss_total - pop_total) <= 2, 1'b1);
            end
            if (fin) begin
                fin_cnt++;
                chk("fin_delay", cyc, last_hs_cyc + 2);
            end
        end
    end

    int base, fbase, iss1, beats1, fin1n, hs1;

    initial begin
        rst = 1'b0; done = 1'b0; done1 = 1'b0; bfpexp = 8'sd0;
        m_ready = 1'b0; m_ready1 = 1'b0;
        repeat (3) tick();
        chk("rst_ctl", {fin, dmaact, m_valid, m_last, busy}, 5'b0);
        chk("rst_dmaa", dmaa, 4'd0);
        chk("rst_data", {m_real, m_imag, m_index, m_exp}, 44'd0);
        chk("rst_u1", {fin1, dmaact1, m_valid1, busy1}, 4'b0);
        rst = 1'b1;
        tick();

        // Frame 1: m_ready held high, latency of the first beat.
        m_ready = 1'b1; bfpexp = -8'sd3; push_frame(-8'sd3); done = 1'b1;
        @(negedge clk); chk("f1_c0_valid", m_valid, 1'b0);
        @(negedge clk); chk("f1_first_rd", {busy, dmaact}, 2'b11);
        @(negedge clk); chk("f1_c2_valid", m_valid, 1'b0);
        @(negedge clk); chk("f1_c3_valid", m_valid, 1'b1);
        wait_fin(1, "f1_fin");

        // done stays high after fin: no second drain.
        base = iss_all;
        repeat (50) tick();
        chk("hold_no_redrain", iss_all - base, 0);
        chk("hold_fin_once", fin_cnt, 1);
        chk("hold_busy", busy, 1'b1);

        // Frame 2: random 30% ready, new exponent, done dropped mid-drain.
        done = 1'b0;
        wait_idle();
        bfpexp = 8'sd5; push_frame(8'sd5); done = 1'b1;
        tick(); tick(); done = 1'b0;
        for (int k = 0; k < 400 && fin_cnt < 2; k++) begin
            m_ready = ($urandom_range(0, 99) < 30);
            tick();
        end
        wait_fin(2, "f2_fin");
        wait_idle();

        // Frame 3: downstream stalled for 20 cycles.
        m_ready = 1'b0; bfpexp = -8'sd7; push_frame(-8'sd7); done = 1'b1;
        tick(); done = 1'b0; base = iss_all;
        repeat (20) tick();
        chk("stall_two_reads", iss_all - base, 2);
        chk("stall_no_rd", dmaact, 1'b0);
        m_ready = 1'b1;
        wait_fin(3, "f3_fin");
        wait_idle();

        // Frame 4: reset in the cycle after bin 3 handshakes.
        bfpexp = 8'sd2; push_frame(8'sd2); base = pop_all; fbase = fin_cnt; done = 1'b1;
        tick(); done = 1'b0;
        for (int k = 0; k < 100 && (pop_all - base) < 4; k++) tick();
        chk("pre_rst_beats", pop_all - base, 4);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ctl", {fin, dmaact, m_valid, m_last, busy}, 5'b0);
        chk("mid_rst_dmaa", dmaa, 4'd0);
        chk("mid_rst_data", {m_real, m_imag, m_index, m_exp}, 44'd0);
        tick();
        sb_q.delete();
        repeat (10) tick();
        chk("rst_no_fin", fin_cnt, fbase);

        // Frame 5: full frame after the abort, starting from index 0.
        bfpexp = -8'sd1; push_frame(-8'sd1); done = 1'b1;
        tick(); done = 1'b0;
        wait_fin(fbase + 1, "f5_fin");

        // Single-bin instance.
        iss1 = 0; beats1 = 0; fin1n = 0; hs1 = -100;
        bfpexp = 8'sd4; m_ready1 = 1'b1; done1 = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (dmaact1) iss1++;
            if (m_valid1) begin
                beats1++;
                hs1 = k;
                chk("u1_beat", {m_index1, m_last1, m_real1, m_imag1, m_exp1},
                    {4'd0, 1'b1, 16'd0, 16'd0, 8'd4});
            end
            if (fin1) begin
                fin1n++;
                chk("u1_fin_delay", k, hs1 + 2);
            end
        end
        chk("u1_reads", iss1, 1);
        chk("u1_beats", beats1, 1);
        chk("u1_fins", fin1n, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
